reorder_buffer: RTL and testbench

- Circular 32-entry reorder buffer that sits directly upstream of the commit unit.
- Accepts in-order allocations from issue/dispatch and captures out-of-order results from the common data bus by ROB tag.
- Presents the head entry (plus delay-slot readiness) to commit; retires on robCommit.
- On rollBack, flushes every entry younger than the branch delay slot.

---
 rtl/reorder_buffer_if.sv | 53 +++++
 rtl/reorder_buffer.sv | 115 +++++++++++
 tb/tb_reorder_buffer.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_if.sv
// Reorder buffer bus: dispatch allocation, CDB writeback and commit-side signals.
// The master modport is the pipeline side that drives requests; the slave
// modport is the reorder buffer itself.
interface reorder_buffer_if #(
    parameter int AW = 5
);
    // Allocation from issue/dispatch
    logic          alloc_req;
    logic [31:0]   alloc_instr;
    logic [4:0]    alloc_dest;
    logic          alloc_ack;
    logic [AW-1:0] alloc_tag;

    // Occupancy
    logic          rob_full;
    logic          rob_empty;
    logic [AW:0]   rob_count;

    // Common data bus writeback
    logic          wb_valid;
    logic [AW-1:0] wb_tag;
    logic [31:0]   wb_value;

    // Commit unit
    logic          robCommit;
    logic          rollBack;
    logic [AW-1:0] robHeadEntry;
    logic [4:0]    robHeadEntryDest;
    logic          robHeadEntryReady;
    logic [31:0]   robHeadEntryInstr;
    logic [31:0]   robHeadEntryValue;
    logic          robPostBranchDelayEntryValid;

    modport master (
        output alloc_req, alloc_instr, alloc_dest,
        output wb_valid, wb_tag, wb_value,
        output robCommit, rollBack,
        input  alloc_ack, alloc_tag,
        input  rob_full, rob_empty, rob_count,
        input  robHeadEntry, robHeadEntryDest, robHeadEntryReady,
        input  robHeadEntryInstr, robHeadEntryValue, robPostBranchDelayEntryValid
    );

    modport slave (
        input  alloc_req, alloc_instr, alloc_dest,
        input  wb_valid, wb_tag, wb_value,
        input  robCommit, rollBack,
        output alloc_ack, alloc_tag,
        output rob_full, rob_empty, rob_count,
        output robHeadEntry, robHeadEntryDest, robHeadEntryReady,
        output robHeadEntryInstr, robHeadEntryValue, robPostBranchDelayEntryValid
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer between dispatch and commit. Entries are allocated
// in order at the tail, completed out of order by CDB tag, and retired in
// order from the head. A mispredicted branch at the head retires itself and
// keeps only its delay slot, discarding every younger entry.
module reorder_buffer #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input logic              clk,
    input logic              rst,
    reorder_buffer_if.slave  bus
);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [AW-1:0]  head;
    logic [AW-1:0]  tail;
    logic [AW:0]    count;
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] ready;
    logic [4:0]     dest_mem  [DEPTH];
    logic [31:0]    instr_mem [DEPTH];
    logic [31:0]    value_mem [DEPTH];

    logic [AW-1:0]  head_next;
    logic [AW-1:0]  head_after;
    logic           full;
    logic           empty;
    logic           do_commit;
    logic           do_rollback;
    logic           do_alloc;
    logic           wb_accept;

    assign head_next   = head + AW'(1);
    assign head_after  = head + AW'(2);
    assign full        = (count == FULL_COUNT);
    assign empty       = (count == '0);
    assign do_rollback = bus.robCommit & bus.rollBack;
    assign do_commit   = bus.robCommit & ~bus.rollBack;

    // Full is judged on the registered count, so a commit in the same cycle
    // does not free a slot for this cycle's allocation. Reset also blocks it.
    assign do_alloc    = rst & bus.alloc_req & ~full & ~do_rollback;

    // Writebacks to empty slots are stale and dropped; during a rollback only
    // the surviving delay slot may still capture its result.
    assign wb_accept   = bus.wb_valid & valid[bus.wb_tag]
                       & (~do_rollback | (bus.wb_tag == head_next));

    assign bus.alloc_ack = do_alloc;
    assign bus.alloc_tag = tail;
    assign bus.rob_full  = full;
    assign bus.rob_empty = empty;
    assign bus.rob_count = count;

    assign bus.robHeadEntry                 = head;
    assign bus.robHeadEntryDest             = dest_mem[head];
    assign bus.robHeadEntryReady            = valid[head] & ready[head];
    assign bus.robHeadEntryInstr            = instr_mem[head];
    assign bus.robHeadEntryValue            = value_mem[head];
    assign bus.robPostBranchDelayEntryValid = valid[head_next] & ready[head_next];

    // Pointers, occupancy and per-entry valid/ready bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
            ready <= '0;
        end else if (do_rollback) begin
            head  <= head_next;
            tail  <= head_after;
            count <= (AW + 1)'(1);
            for (int i = 0; i < DEPTH; i++) begin
                if (AW'(i) != head_next) begin
                    valid[i] <= 1'b0;
                    ready[i] <= 1'b0;
                end
            end
            if (wb_accept) begin
                ready[bus.wb_tag] <= 1'b1;
            end
        end else begin
            if (wb_accept) begin
                ready[bus.wb_tag] <= 1'b1;
            end
            if (do_commit) begin
                valid[head] <= 1'b0;
                ready[head] <= 1'b0;
                head        <= head_next;
            end
            if (do_alloc) begin
                valid[tail] <= 1'b1;
                ready[tail] <= 1'b0;
                tail        <= tail + AW'(1);
            end
            case ({do_alloc, do_commit})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Payload storage; contents of empty slots are don't-care, so no reset.
    always_ff @(posedge clk) begin
        if (do_alloc) begin
            dest_mem[tail]  <= bus.alloc_dest;
            instr_mem[tail] <= bus.alloc_instr;
        end
        if (wb_accept) begin
            value_mem[bus.wb_tag] <= bus.wb_value;
        end
    end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer: ordering, full, wrap,
// rollback, stale writeback and mid-operation reset.
module tb_reorder_buffer;
    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    reorder_buffer_if bus ();

    reorder_buffer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alloc_req   = 1'b0;
        bus.alloc_instr = '0;
        bus.alloc_dest  = '0;
        bus.wb_valid    = 1'b0;
        bus.wb_tag      = '0;
        bus.wb_value    = '0;
        bus.robCommit   = 1'b0;
        bus.rollBack    = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic do_alloc(input logic [31:0] instr, input logic [4:0] dest, input logic [4:0] exp_tag);
        bus.alloc_req   = 1'b1;
        bus.alloc_instr = instr;
        bus.alloc_dest  = dest;
        #1;
        check_output("alloc_ack", bus.alloc_ack, 1);
        check_output("alloc_tag", bus.alloc_tag, exp_tag);
        tick();
        bus.alloc_req = 1'b0;
    endtask

    task automatic do_wb(input logic [4:0] tag, input logic [31:0] value);
        bus.wb_valid = 1'b1;
        bus.wb_tag   = tag;
        bus.wb_value = value;
        tick();
        bus.wb_valid = 1'b0;
    endtask

    task automatic do_commit();
        bus.robCommit = 1'b1;
        tick();
        bus.robCommit = 1'b0;
    endtask

    // Walk the pointers forward by n entries, leaving the buffer empty.
    task automatic advance(input int n);
        for (int k = 0; k < n; k++) begin
            do_alloc(32'h1000 + k, 5'(k), 5'(k));
            do_wb(5'(k), 32'h2000 + k);
            do_commit();
        end
    endtask

    // Commit may only be issued when the head entry has completed.
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.robCommit === 1'b1)
            check_output("commit_head_ready", bus.robHeadEntryReady, 1);
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        idle_inputs();
        rst = 1'b0;
        tick();
        tick();

        // Reset state
        check_output("rst_empty", bus.rob_empty, 1);
        check_output("rst_full", bus.rob_full, 0);
        check_output("rst_count", bus.rob_count, 0);
        check_output("rst_head", bus.robHeadEntry, 0);
        check_output("rst_head_ready", bus.robHeadEntryReady, 0);
        check_output("rst_post", bus.robPostBranchDelayEntryValid, 0);
        check_output("rst_ack", bus.alloc_ack, 0);
        rst = 1'b1;

        // Basic in-order retirement with out-of-order completion
        for (int i = 0; i < 3; i++) do_alloc(32'h100 + i, 5'(i + 4), 5'(i));
        check_output("basic_count3", bus.rob_count, 3);
        do_wb(5'd2, 32'h22);
        check_output("basic_ready_after_t2", bus.robHeadEntryReady, 0);
        do_wb(5'd0, 32'h11);
        check_output("basic_ready_after_t0", bus.robHeadEntryReady, 1);
        check_output("basic_head_dest", bus.robHeadEntryDest, 4);
        check_output("basic_head_instr", bus.robHeadEntryInstr, 32'h100);
        check_output("basic_post_before_t1", bus.robPostBranchDelayEntryValid, 0);
        do_wb(5'd1, 32'h33);
        check_output("basic_post_after_t1", bus.robPostBranchDelayEntryValid, 1);
        check_output("basic_retire0", bus.robHeadEntryValue, 32'h11);
        do_commit();
        check_output("basic_retire1", bus.robHeadEntryValue, 32'h33);
        check_output("basic_head1", bus.robHeadEntry, 1);
        do_commit();
        check_output("basic_retire2", bus.robHeadEntryValue, 32'h22);
        check_output("basic_count1", bus.rob_count, 1);
        do_commit();
        check_output("basic_empty", bus.rob_empty, 1);
        check_output("basic_head3", bus.robHeadEntry, 3);

        // Full buffer
        apply_reset();
        for (int i = 0; i < 32; i++) do_alloc(32'h300 + i, 5'(i), 5'(i));
        check_output("full_flag", bus.rob_full, 1);
        check_output("full_empty", bus.rob_empty, 0);
        check_output("full_count", bus.rob_count, 32);
        bus.alloc_req = 1'b1;
        #1;
        check_output("full_33rd_ack", bus.alloc_ack, 0);
        bus.alloc_req = 1'b0;
        do_wb(5'd0, 32'hA0);
        bus.robCommit = 1'b1;
        bus.alloc_req = 1'b1;
        #1;
        check_output("full_commit_alloc_ack", bus.alloc_ack, 0);
        tick();
        bus.robCommit = 1'b0;
        #1;
        check_output("full_next_ack", bus.alloc_ack, 1);
        check_output("full_next_tag", bus.alloc_tag, 0);
        tick();
        bus.alloc_req = 1'b0;
        check_output("full_refill_count", bus.rob_count, 32);
        check_output("full_head1", bus.robHeadEntry, 1);

        // Wrap-around at head = 30
        apply_reset();
        advance(30);
        check_output("wrap_head30", bus.robHeadEntry, 30);
        check_output("wrap_empty", bus.rob_empty, 1);
        do_alloc(32'h400, 5'd1, 5'd30);
        do_alloc(32'h401, 5'd2, 5'd31);
        do_alloc(32'h402, 5'd3, 5'd0);
        do_alloc(32'h403, 5'd4, 5'd1);
        check_output("wrap_count4", bus.rob_count, 4);
        check_output("wrap_post31_pending", bus.robPostBranchDelayEntryValid, 0);
        do_wb(5'd31, 32'h31);
        check_output("wrap_post31_done", bus.robPostBranchDelayEntryValid, 1);
        do_wb(5'd30, 32'h30);
        do_commit();
        check_output("wrap_head31", bus.robHeadEntry, 31);
        check_output("wrap_post0_pending", bus.robPostBranchDelayEntryValid, 0);
        do_wb(5'd0, 32'h40);
        check_output("wrap_post0_done", bus.robPostBranchDelayEntryValid, 1);
        check_output("wrap_count3", bus.rob_count, 3);

        // Rollback at head = 5
        apply_reset();
        advance(5);
        for (int i = 5; i < 10; i++) do_alloc(32'h500 + i, 5'(i), 5'(i));
        do_wb(5'd5, 32'h55);
        do_wb(5'd6, 32'h66);
        check_output("rb_pre_post", bus.robPostBranchDelayEntryValid, 1);
        bus.robCommit = 1'b1;
        bus.rollBack  = 1'b1;
        bus.wb_valid  = 1'b1;
        bus.wb_tag    = 5'd8;
        bus.wb_value  = 32'h88;
        bus.alloc_req = 1'b1;
        #1;
        check_output("rb_alloc_suppressed", bus.alloc_ack, 0);
        tick();
        idle_inputs();
        #1;
        check_output("rb_head", bus.robHeadEntry, 6);
        check_output("rb_count", bus.rob_count, 1);
        check_output("rb_tail", bus.alloc_tag, 7);
        check_output("rb_slot_value", bus.robHeadEntryValue, 32'h66);
        check_output("rb_post_flushed", bus.robPostBranchDelayEntryValid, 0);
        do_alloc(32'h777, 5'd7, 5'd7);
        do_commit();
        check_output("rb_head7", bus.robHeadEntry, 7);
        check_output("rb_tag8_not_ready", bus.robPostBranchDelayEntryValid, 0);

        // Stale writebacks to unallocated tags
        do_wb(5'd20, 32'hDEAD);
        do_wb(5'd8, 32'hBEEF);
        check_output("stale_head_ready", bus.robHeadEntryReady, 0);
        check_output("stale_post", bus.robPostBranchDelayEntryValid, 0);
        check_output("stale_count", bus.rob_count, 1);
        check_output("stale_head", bus.robHeadEntry, 7);
        do_wb(5'd7, 32'h77);
        check_output("stale_then_real", bus.robHeadEntryValue, 32'h77);

        // Reset in the middle of activity
        for (int i = 8; i < 17; i++) do_alloc(32'h600 + i, 5'(i), 5'(i));
        check_output("mid_count10", bus.rob_count, 10);
        rst           = 1'b0;
        bus.alloc_req = 1'b1;
        bus.robCommit = 1'b1;
        bus.wb_valid  = 1'b1;
        bus.wb_tag    = 5'd9;
        bus.wb_value  = 32'h99;
        tick();
        idle_inputs();
        rst = 1'b1;
        #1;
        check_output("mid_count", bus.rob_count, 0);
        check_output("mid_head", bus.robHeadEntry, 0);
        check_output("mid_empty", bus.rob_empty, 1);
        check_output("mid_tail", bus.alloc_tag, 0);
        check_output("mid_head_ready", bus.robHeadEntryReady, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
